// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
package freq_div_pkg;

    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    localparam int unsigned DIV_MIN = 2;

    // Number of high cycles in one output period; odd ratios get the extra cycle.
    function automatic int unsigned high_count(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Divide-ratio configuration channel: valid/ready transfer plus an illegal-ratio pulse.
interface freq_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/freq_div_core.sv
// Divide counter with wrap detection and a glitch-free clk_out flop decoded from next-count.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             run_nxt,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] div_nxt,
    output logic             wrap,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;

    assign wrap = run && (cnt == div - DIV_W'(1));

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_nxt = '0;
        if (run && !wrap) cnt_nxt = cnt + DIV_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            clk_out <= run_nxt && (32'(cnt_nxt) < high_count(32'(div_nxt)));
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Divider controller: FSM, config handshake, pending ratio, graceful start/stop.
// Optional FREQ_DIV_CHG_CNT_EN adds an 8-bit count of active-ratio loads on chg_cnt.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    freq_div_ctrl_if.slave   cfg,
    output logic [DIV_W-1:0] active_div,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
`ifdef FREQ_DIV_CHG_CNT_EN
    ,
    output logic [7:0]       chg_cnt
`endif
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] active_div_nxt;
    logic [DIV_W-1:0] pend_div, pend_div_nxt;
    logic             stop_req, stop_req_nxt;
    logic             xfer, legal, load, wrap;

    assign cfg.cfg_ready = (state != PEND);
    assign busy          = (state != STOP);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign legal         = (32'(cfg.cfg_div) >= DIV_MIN);
    assign tick          = wrap;

    always_comb begin
        state_nxt      = state;
        active_div_nxt = active_div;
        pend_div_nxt   = pend_div;
        stop_req_nxt   = stop_req;
        load           = 1'b0;
        unique case (state)
            STOP: begin
                stop_req_nxt = 1'b0;
                if (xfer && legal) begin
                    active_div_nxt = cfg.cfg_div;
                    load           = 1'b1;
                end
                if (en) state_nxt = RUN;
            end
            RUN: begin
                stop_req_nxt = !en;
                // A ratio arriving on the stopping boundary is loaded directly, as in STOP.
                if (wrap && stop_req) begin
                    state_nxt    = STOP;
                    stop_req_nxt = 1'b0;
                    if (xfer && legal) begin
                        active_div_nxt = cfg.cfg_div;
                        load           = 1'b1;
                    end
                end else if (xfer && legal) begin
                    pend_div_nxt = cfg.cfg_div;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                stop_req_nxt = !en;
                if (wrap) begin
                    active_div_nxt = pend_div;
                    load           = 1'b1;
                    state_nxt      = stop_req ? STOP : RUN;
                    if (stop_req) stop_req_nxt = 1'b0;
                end
            end
            default: state_nxt = STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STOP;
            active_div  <= DIV_W'(DIV_RST);
            pend_div    <= '0;
            stop_req    <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            active_div  <= active_div_nxt;
            pend_div    <= pend_div_nxt;
            stop_req    <= stop_req_nxt;
            cfg.cfg_err <= xfer && !legal;
        end
    end

`ifdef FREQ_DIV_CHG_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)       chg_cnt <= '0;
        else if (load) chg_cnt <= chg_cnt + 8'd1;
    end
`endif

    freq_div_core #(.DIV_W(DIV_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .run     (state != STOP),
        .run_nxt (state_nxt != STOP),
        .div     (active_div),
        .div_nxt (active_div_nxt),
        .wrap    (wrap),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed scenarios then random traffic against a period-level model.
module tb_freq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] active_div;
    logic       clk_out, tick, busy;
`ifdef FREQ_DIV_CHG_CNT_EN
    logic [7:0] chg_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whether the output runs, the position in the current period,
    // the ratio in force, a queue holding at most one waiting ratio, and a stop request.
    bit m_run, m_stopping, m_err;
    int m_n, m_phase, m_chg;
    int m_pend[$];

    freq_div_ctrl_if #(.DIV_W(8)) cfg ();

    freq_div_ctrl #(.DIV_W(8), .DIV_RST(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg        (cfg),
        .active_div (active_div),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy)
`ifdef FREQ_DIV_CHG_CNT_EN
        ,
        .chg_cnt    (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare every output.
    task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
        bit acc, good;
        rst           = r;
        en            = e;
        cfg.cfg_valid = v;
        cfg.cfg_div   = d;
        @(posedge clk);
        if (r) begin
            m_run = 0; m_stopping = 0; m_err = 0;
            m_n = 3; m_phase = 0; m_chg = 0;
            m_pend.delete();
        end else begin
            acc   = v && (m_pend.size() == 0);
            m_err = acc && (d < 2);
            good  = acc && (d >= 2);
            if (!m_run) begin
                if (good) begin m_n = d; m_chg = (m_chg + 1) % 256; end
                if (e) begin m_run = 1; m_phase = 0; end
            end else if (m_phase == m_n - 1) begin
                m_phase = 0;
                if (m_pend.size() > 0) begin
                    m_n = m_pend.pop_front();
                    m_chg = (m_chg + 1) % 256;
                end else if (good && m_stopping) begin
                    m_n = d;
                    m_chg = (m_chg + 1) % 256;
                end else if (good) begin
                    m_pend.push_back(int'(d));
                end
                if (m_stopping) m_run = 0;
            end else begin
                m_phase++;
                if (good) m_pend.push_back(int'(d));
            end
            m_stopping = m_run && !e;
        end
        #1;
        check("clk_out",    32'(clk_out),       32'(m_run && (m_phase < (m_n + 1) / 2)));
        check("tick",       32'(tick),          32'(m_run && (m_phase == m_n - 1)));
        check("busy",       32'(busy),          32'(m_run));
        check("cfg_ready",  32'(cfg.cfg_ready), 32'(m_pend.size() == 0));
        check("cfg_err",    32'(cfg.cfg_err),   32'(m_err));
        check("active_div", 32'(active_div),    32'(m_n));
`ifdef FREQ_DIV_CHG_CNT_EN
        check("chg_cnt",    32'(chg_cnt),       32'(m_chg));
`endif
    endtask

    initial begin
        logic       e, v, r;
        logic [7:0] d;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_div", 32'(active_div), 32'd3);
        check("rst_ready", 32'(cfg.cfg_ready), 32'd1);
        step(0, 0, 0, 0);

        // Start at N=3: 1,1,0 with tick on the low cycle
        step(0, 1, 0, 0);
        check("start_clk_out", 32'(clk_out), 32'd1);
        repeat (8) step(0, 1, 0, 0);

        // Ratio 4 offered at cnt=0 switches at the wrap
        for (int i = 0; i < 10 && m_phase != 0; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 8'd4);
        check("ready_drop", 32'(cfg.cfg_ready), 32'd0);
        for (int i = 0; i < 10 && m_pend.size() > 0; i++) step(0, 1, 0, 0);
        check("div4_applied", 32'(active_div), 32'd4);
        repeat (8) step(0, 1, 0, 0);

        // Illegal ratios while running
        step(0, 1, 1, 8'd1);
        check("err_run_1", 32'(cfg.cfg_err), 32'd1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 8'd0);
        step(0, 1, 0, 0);
        check("div_kept_run", 32'(active_div), 32'd4);

        // N=5, drop en at cnt=1, period completes then STOP
        step(0, 1, 1, 8'd5);
        for (int i = 0; i < 10 && m_pend.size() > 0; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 10 && m_phase != 1; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 10 && m_run; i++) step(0, 0, 0, 0);
        check("stopped_busy", 32'(busy), 32'd0);
        check("stopped_clk", 32'(clk_out), 32'd0);

        // Illegal ratios while stopped
        step(0, 0, 1, 8'd1);
        check("err_stop_1", 32'(cfg.cfg_err), 32'd1);
        step(0, 0, 1, 8'd0);
        step(0, 0, 0, 0);
        check("div_kept_stop", 32'(active_div), 32'd5);

        // Reset while a ratio of 7 is pending
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 8'd7);
        check("pend_ready", 32'(cfg.cfg_ready), 32'd0);
        step(1, 1, 0, 0);
        check("rst_pend_div", 32'(active_div), 32'd3);
        check("rst_pend_ready", 32'(cfg.cfg_ready), 32'd1);
        check("rst_pend_busy", 32'(busy), 32'd0);
        repeat (6) step(0, 0, 0, 0);
        check("pend_lost", 32'(active_div), 32'd3);

        // Three legal loads and one illegal in STOP
        step(0, 0, 1, 8'd5);
        step(0, 0, 1, 8'd6);
        step(0, 0, 1, 8'd0);
        step(0, 0, 1, 8'd9);
        check("div_last", 32'(active_div), 32'd9);
`ifdef FREQ_DIV_CHG_CNT_EN
        check("chg_cnt_3", 32'(chg_cnt), 32'd3);
`endif

        // Randomized traffic
        e = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) e = !e;
            v = ($urandom_range(0, 3) == 0);
            d = 8'($urandom_range(0, 9));
            r = ($urandom_range(0, 499) == 0);
            step(r, e, v, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Runtime-programmable clock-divider controller. It sequences a single posedge-only divide counter, accepts new divide ratios over a valid/ready handshake, and applies them only at output-period boundaries so that `clk_out` never produces a runt pulse. It also starts and stops the divided output gracefully. It sits between the register/config logic and any logic consuming a divided clock enable (`tick`) or a divided level (`clk_out`).

## Interface
- `DIV_W`, default 8: width of the divide ratio.
- `DIV_RST`, default 3: active divide ratio after reset; must be in 2..2^DIV_W-1.
- `clk` input, 1 bit: the only clock; all logic is posedge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `en` input, 1 bit: run request (level).
- `cfg_valid` input, 1 bit: a new ratio is offered.
- `cfg_div` input, DIV_W bits: the offered ratio N.
- `cfg_ready` output, 1 bit: a config can be accepted this cycle.
- `cfg_err` output, 1 bit: one-cycle pulse when an accepted ratio is illegal (N<2) and was discarded.
- `active_div` output, DIV_W bits: the ratio currently in effect.
- `clk_out` output, 1 bit: divided level (flop output).
- `tick` output, 1 bit: one-cycle pulse on the last cycle of each output period.
- `busy` output, 1 bit: high when the state is not STOP.

## Operation
- Handshake: a transfer occurs when `cfg_valid && cfg_ready`. `cfg_ready` = (state != PEND); this is a one-deep pending slot.
- Legality: a transferred N<2 is dropped, `cfg_err` pulses the next cycle, and the state is unchanged.
- States:
  - STOP: `cnt`=0, `clk_out`=0, `tick`=0.
    - A legal config loads `active_div` directly and stays in STOP.
    - `en`=1 goes to RUN with `cnt`=0.
  - RUN: `cnt` counts 0..N-1 and wraps.
    - A legal config stores it in `pend_div` and goes to PEND.
  - PEND: counting continues with the old N.
    - At `cnt`==N-1: `active_div`<=`pend_div`, `cnt`<=0, and the state goes to RUN.
- Stop: `en` sampled low in RUN or PEND sets `stop_req`. At the next `cnt`==N-1 the state goes to STOP. A pending ratio is applied at that same boundary.
- `en` re-raised before that boundary clears `stop_req`.
- Simultaneous events:
  - Config accepted while `en` falls: both are honoured; the ratio is applied at the stopping boundary.
  - Config accepted in STOP in the same cycle `en` rises: the new ratio is used from the first period.
- `clk_out` is high while `cnt` < (N+1)>>1 and low otherwise. For odd N this gives one extra high cycle; there is no 50% duty for odd N, by design.
- `tick` = (state != STOP) && (`cnt` == N-1).

## Timing
- Reset values:
  - state=STOP, `cnt`=0, `active_div`=DIV_RST, `pend_div`=0, `stop_req`=0.
  - `clk_out`=0, `tick`=0, `cfg_err`=0, `busy`=0, `cfg_ready`=1.
- Reset mid-operation discards any pending ratio. All outputs reach reset values the cycle after `rst` is sampled high.
- Start latency: `en` sampled high at edge t gives `cnt`=0 and `clk_out`=1 from edge t (visible cycle t+1).
- `clk_out` is a flop loaded from the decode of next-`cnt`, so it is aligned with `cnt` and glitch-free.
- `cfg_ready` drops the cycle after a RUN-state transfer and rises the cycle after the ratio is applied.
- `active_div` changes on the same edge where `cnt` wraps to 0.

## Configuration
- `FREQ_DIV_CHG_CNT_EN`
  - When defined: adds output `chg_cnt` (8 bits, reset 0). It increments, wrapping at 255, on every edge where `active_div` is loaded with a legal ratio; this covers both STOP loads and boundary loads.
  - When undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `freq_div_pkg`:
  - state enum {STOP, RUN, PEND}.
  - constant `DIV_MIN`=2.
  - function computing the high count (N+1)>>1.
- Sub-module `freq_div_core`: counter, wrap detection, `clk_out` flop and `tick` decode. It takes `run` and `div` and reports `wrap`.
- `freq_div_ctrl` contains the FSM, the handshake, the pending register and the optional change counter.

## Test plan
- Reset, then `en`=1 with the default N=3: `clk_out` runs 1,1,0 repeating; `tick` is high every third cycle on the low cycle; `busy`=1.
- While running at N=3, offer `cfg_div`=4 at `cnt`=0: `cfg_ready` drops next cycle; the ratio switches at wrap; then 1,1,0,0 repeating; `active_div`=4 on the wrap edge.
- Offer `cfg_div`=1, then `cfg_div`=0, in STOP and in RUN: each is accepted, `cfg_err` pulses once, and `active_div` is unchanged.
- Drop `en` at `cnt`=1 with N=5: the period finishes (ticks at `cnt`=4), then STOP with `clk_out`=0 and `busy`=0.
- Assert `rst` in PEND with `pend_div`=7: next cycle STOP, `active_div`=3, `cfg_ready`=1, and the pending ratio is lost.
- With `FREQ_DIV_CHG_CNT_EN` defined: 3 legal changes plus 1 illegal change give `chg_cnt`=3.
